// File: rtl/csr_port_arbiter_pkg.sv
// Shared types and constants for the CSR port arbiter.
package csr_port_arbiter_pkg;

   localparam int CSR_ADDR_W = 14;
   localparam int CSR_DATA_W = 32;

   typedef enum logic [1:0] {
      CSR_OP_RD   = 2'b00,
      CSR_OP_WR   = 2'b01,
      CSR_OP_XCHG = 2'b10,
      CSR_OP_ILL  = 2'b11
   } csr_op_e;

   typedef enum logic {
      SRC_EXC = 1'b0,
      SRC_EX  = 1'b1
   } csr_src_e;

endpackage

// File: rtl/csr_port_arbiter.sv
// Arbitrates the single CSR-file port between the exception unit and the
// EX-stage privilege unit; each CSR instruction runs as read, then optional
// write, then a one-cycle response to the requester that issued it.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a request; fixed priority exception over EX
// S_READ  | csr_ren asserted for the latched address
// S_CAPT  | CSR file read data captured as the old value
// S_WRITE | csr_wen asserted with plain or mask-merged write data
// S_RESP  | response pulse to the source with the old value / error
module csr_port_arbiter
   import csr_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = CSR_ADDR_W,
   parameter int DATA_W = CSR_DATA_W
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              exc_valid,
   output logic              exc_ready,
   input  logic [1:0]        exc_op,
   input  logic [ADDR_W-1:0] exc_addr,
   input  logic [DATA_W-1:0] exc_wdata,
   input  logic [DATA_W-1:0] exc_mask,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [1:0]        ex_op,
   input  logic [ADDR_W-1:0] ex_addr,
   input  logic [DATA_W-1:0] ex_wdata,
   input  logic [DATA_W-1:0] ex_mask,
   output logic              exc_resp_valid,
   output logic              ex_resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   input  logic              flush,
   output logic              busy,
   output logic [ADDR_W-1:0] csr_addr,
   output logic              csr_ren,
   output logic              csr_wen,
   output logic [DATA_W-1:0] csr_wdata,
   input  logic [DATA_W-1:0] csr_rdata
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_CAPT  = 3'd2,
      S_WRITE = 3'd3,
      S_RESP  = 3'd4
   } state_e;

   state_e            state_q;
   csr_op_e           op_q;
   csr_src_e          src_q;
   logic              err_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] mask_q;
   logic [DATA_W-1:0] old_q;

   logic              csr_ren_q;
   logic              csr_wen_q;
   logic [ADDR_W-1:0] csr_addr_q;
   logic [DATA_W-1:0] csr_wdata_q;
   logic              exc_resp_q;
   logic              ex_resp_q;
   logic [DATA_W-1:0] resp_rdata_q;
   logic              resp_err_q;

   logic              exc_acc;
   logic              ex_acc;
   logic              ex_abort;
   csr_op_e           op_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] wdata_d;
   logic [DATA_W-1:0] mask_d;

   // XCHG: masked bits take the new value, the rest keep the old CSR value.
   function automatic logic [DATA_W-1:0] xchg_merge(input logic [DATA_W-1:0] wdata,
                                                    input logic [DATA_W-1:0] mask,
                                                    input logic [DATA_W-1:0] old);
      return (wdata & mask) | (old & ~mask);
   endfunction

   // Arbitration in IDLE and selection of the winning request's fields.
   always_comb begin
      exc_acc = 1'b0;
      ex_acc  = 1'b0;
      if (state_q == S_IDLE) begin
         exc_acc = exc_valid;
         ex_acc  = ex_valid & ~exc_valid & ~flush;
      end
      op_d    = exc_acc ? csr_op_e'(exc_op) : csr_op_e'(ex_op);
      addr_d  = exc_acc ? exc_addr  : ex_addr;
      wdata_d = exc_acc ? exc_wdata : ex_wdata;
      mask_d  = exc_acc ? exc_mask  : ex_mask;
   end

   assign ex_abort = (src_q == SRC_EX) & flush;

   // Transaction sequencer with registered CSR-port and response outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= S_IDLE;
         op_q         <= CSR_OP_RD;
         src_q        <= SRC_EXC;
         err_q        <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         mask_q       <= '0;
         old_q        <= '0;
         csr_ren_q    <= 1'b0;
         csr_wen_q    <= 1'b0;
         csr_addr_q   <= '0;
         csr_wdata_q  <= '0;
         exc_resp_q   <= 1'b0;
         ex_resp_q    <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         csr_ren_q   <= 1'b0;
         csr_wen_q   <= 1'b0;
         csr_addr_q  <= '0;
         csr_wdata_q <= '0;
         exc_resp_q  <= 1'b0;
         ex_resp_q   <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (exc_acc || ex_acc) begin
                  op_q    <= op_d;
                  addr_q  <= addr_d;
                  wdata_q <= wdata_d;
                  mask_q  <= mask_d;
                  src_q   <= ex_acc ? SRC_EX : SRC_EXC;
                  err_q   <= (op_d == CSR_OP_ILL);
                  old_q   <= '0;
                  if (op_d == CSR_OP_ILL) begin
                     // Illegal ops never touch the CSR file.
                     state_q      <= S_RESP;
                     resp_rdata_q <= '0;
                     resp_err_q   <= 1'b1;
                     exc_resp_q   <= exc_acc;
                     ex_resp_q    <= ex_acc;
                  end else begin
                     state_q    <= S_READ;
                     csr_ren_q  <= 1'b1;
                     csr_addr_q <= addr_d;
                  end
               end
            end
            S_READ: begin
               state_q <= ex_abort ? S_IDLE : S_CAPT;
            end
            S_CAPT: begin
               if (ex_abort) begin
                  state_q <= S_IDLE;
               end else begin
                  old_q <= csr_rdata;
                  if (op_q == CSR_OP_RD) begin
                     state_q      <= S_RESP;
                     resp_rdata_q <= csr_rdata;
                     resp_err_q   <= err_q;
                     exc_resp_q   <= (src_q == SRC_EXC);
                     ex_resp_q    <= (src_q == SRC_EX);
                  end else begin
                     state_q     <= S_WRITE;
                     csr_wen_q   <= 1'b1;
                     csr_addr_q  <= addr_q;
                     csr_wdata_q <= (op_q == CSR_OP_XCHG) ?
                                    xchg_merge(wdata_q, mask_q, csr_rdata) : wdata_q;
                  end
               end
            end
            S_WRITE: begin
               // The write has already been issued; a flush here only drops the response.
               state_q      <= S_RESP;
               resp_rdata_q <= old_q;
               resp_err_q   <= err_q;
               exc_resp_q   <= (src_q == SRC_EXC);
               ex_resp_q    <= (src_q == SRC_EX) & ~flush;
            end
            S_RESP: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign exc_ready      = exc_acc;
   assign ex_ready       = ex_acc;
   assign exc_resp_valid = exc_resp_q;
   assign ex_resp_valid  = ex_resp_q & ~flush;
   assign resp_rdata     = resp_rdata_q;
   assign resp_err       = resp_err_q;
   assign busy           = (state_q != S_IDLE);
   assign csr_ren        = csr_ren_q;
   assign csr_wen        = csr_wen_q;
   assign csr_addr       = csr_addr_q;
   assign csr_wdata      = csr_wdata_q;

endmodule

// File: tb/tb_csr_port_arbiter.sv
// Bench for csr_port_arbiter: a 16-entry CSR file model drives csr_rdata, a
// transaction-level reference model predicts reads, writes and responses,
// and a monitor compares whatever the DUT presents against queued predictions.
module tb_csr_port_arbiter;

   logic        clk = 1'b0;
   logic        rstn;
   logic        exc_valid, ex_valid, exc_ready, ex_ready;
   logic [1:0]  exc_op, ex_op;
   logic [13:0] exc_addr, ex_addr;
   logic [31:0] exc_wdata, ex_wdata, exc_mask, ex_mask;
   logic        exc_resp_valid, ex_resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        flush;
   logic        busy;
   logic [13:0] csr_addr;
   logic        csr_ren, csr_wen;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;

   csr_port_arbiter dut (
      .clk(clk), .rstn(rstn),
      .exc_valid(exc_valid), .exc_ready(exc_ready), .exc_op(exc_op),
      .exc_addr(exc_addr), .exc_wdata(exc_wdata), .exc_mask(exc_mask),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
      .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_mask(ex_mask),
      .exc_resp_valid(exc_resp_valid), .ex_resp_valid(ex_resp_valid),
      .resp_rdata(resp_rdata), .resp_err(resp_err), .flush(flush), .busy(busy),
      .csr_addr(csr_addr), .csr_ren(csr_ren), .csr_wen(csr_wen),
      .csr_wdata(csr_wdata), .csr_rdata(csr_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // CSR file model: registered read, write on the clock edge.
   logic [31:0] mem [16];
   logic [31:0] seed [16];
   logic        mem_load;
   always @(posedge clk) begin
      if (mem_load) begin
         for (int i = 0; i < 16; i++) mem[i] <= seed[i];
      end else begin
         if (csr_ren) csr_rdata <= mem[csr_addr[3:0]];
         if (csr_wen) mem[csr_addr[3:0]] <= csr_wdata;
      end
   end

   typedef struct {int c; logic [13:0] a; logic [31:0] d;} acc_t;
   typedef struct {int c; int src; logic [31:0] d; logic e;} resp_t;
   acc_t        ren_q[$];
   acc_t        wr_q[$];
   resp_t       resp_q[$];
   logic [31:0] shadow [16];

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_exc_ready"}, exc_ready, 0);
      chk({tag, "_ex_ready"}, ex_ready, 0);
      chk({tag, "_exc_resp_valid"}, exc_resp_valid, 0);
      chk({tag, "_ex_resp_valid"}, ex_resp_valid, 0);
      chk({tag, "_resp_rdata"}, resp_rdata, 0);
      chk({tag, "_resp_err"}, resp_err, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_csr_addr"}, csr_addr, 0);
      chk({tag, "_csr_ren"}, csr_ren, 0);
      chk({tag, "_csr_wen"}, csr_wen, 0);
      chk({tag, "_csr_wdata"}, csr_wdata, 0);
   endtask

   // Reference model: predicts the whole transaction from the accept cycle.
   // Latency from accept: illegal 1, RD 3, WR/XCHG 4; write issued at +3.
   task automatic model(input int src, input logic [1:0] op, input logic [13:0] a,
                        input logic [31:0] wd, input logic [31:0] mk, input int f,
                        input bit rst_mid, input int t, output int free);
      int lat;
      bit abort_t = 1'b0;
      bit supp = 1'b0;
      logic [31:0] old, nv;
      lat = (op == 2'b11) ? 1 : (op == 2'b00) ? 3 : 4;
      if (op != 2'b11) ren_q.push_back('{t + 1, a, 32'h0});
      if (rst_mid) begin
         free = t + 2;
         return;
      end
      if (src == 1 && f >= 1 && f <= lat) begin
         if (op != 2'b11 && f <= 2) abort_t = 1'b1;
         else supp = 1'b1;
      end
      old  = shadow[a[3:0]];
      free = abort_t ? t + f + 1 : t + lat + 1;
      if (!abort_t && (op == 2'b01 || op == 2'b10)) begin
         nv = (op == 2'b01) ? wd : ((wd & mk) | (old & ~mk));
         shadow[a[3:0]] = nv;
         wr_q.push_back('{t + 3, a, nv});
      end
      if (!abort_t && !supp)
         resp_q.push_back('{t + lat, src, (op == 2'b11) ? 32'h0 : old, (op == 2'b11)});
   endtask

   task automatic drive_port(input int src, input logic [1:0] op, input logic [13:0] a,
                             input logic [31:0] wd, input logic [31:0] mk);
      if (src == 0) begin
         exc_valid = 1'b1; exc_op = op; exc_addr = a; exc_wdata = wd; exc_mask = mk;
      end else begin
         ex_valid = 1'b1; ex_op = op; ex_addr = a; ex_wdata = wd; ex_mask = mk;
      end
   endtask

   // Expects acceptance in the current cycle (arbiter is idle); bounded retry.
   task automatic accept(input int src, output int t);
      int n = 0;
      @(negedge clk);
      while (!(src == 0 ? exc_ready : ex_ready) && n < 8) begin
         @(negedge clk);
         n++;
      end
      chk("accept_ready", (src == 0) ? exc_ready : ex_ready, 1);
      chk("accept_delay", n, 0);
      t = cyc;
   endtask

   // Runs the in-flight cycles; flush is driven in cycle t+f. Returns at the idle cycle.
   task automatic finish(input int src, input int t, input int free, input int f,
                         input bit chk_ex_blocked);
      @(posedge clk); #1;
      if (src == 0) exc_valid = 1'b0; else ex_valid = 1'b0;
      for (int k = 1; t + k < free; k++) begin
         flush = (k == f);
         @(negedge clk);
         chk("busy_in_flight", busy, 1);
         if (chk_ex_blocked) chk("ex_blocked_while_busy", ex_ready, 0);
         @(posedge clk); #1;
      end
      flush = 1'b0;
   endtask

   task automatic run_txn(input int src, input logic [1:0] op, input logic [13:0] a,
                          input logic [31:0] wd, input logic [31:0] mk, input int f,
                          input bit pre_flush, input bit rst_mid);
      int t, free;
      drive_port(src, op, a, wd, mk);
      if (pre_flush && src == 1) begin
         flush = 1'b1;
         @(negedge clk);
         chk("flush_blocks_ex_accept", ex_ready, 0);
         @(posedge clk); #1;
         flush = 1'b0;
      end
      accept(src, t);
      model(src, op, a, wd, mk, f, rst_mid, t, free);
      finish(src, t, free, rst_mid ? 0 : f, 1'b0);
      if (rst_mid) begin
         rstn = 1'b0;
         @(negedge clk);
         chk_all_zero("rst_mid");
         @(posedge clk); #1;
         rstn = 1'b1;
      end
   endtask

   task automatic run_both(input logic [1:0] opx, input logic [13:0] ax, input logic [31:0] wdx,
                           input logic [31:0] mkx, input int fx,
                           input logic [1:0] ope, input logic [13:0] ae, input logic [31:0] wde,
                           input logic [31:0] mke);
      int t, free, t2, free2;
      drive_port(0, opx, ax, wdx, mkx);
      drive_port(1, ope, ae, wde, mke);
      @(negedge clk);
      chk("both_exc_ready", exc_ready, 1);
      chk("both_ex_ready", ex_ready, 0);
      t = cyc;
      model(0, opx, ax, wdx, mkx, fx, 1'b0, t, free);
      finish(0, t, free, fx, 1'b1);
      accept(1, t2);
      model(1, ope, ae, wde, mke, 0, 1'b0, t2, free2);
      finish(1, t2, free2, 0, 1'b0);
   endtask

   // Monitor: compares every DUT-presented event against the prediction queues.
   always @(negedge clk) begin : mon
      resp_t r;
      acc_t  w;
      if (rstn) begin
         if (exc_resp_valid || ex_resp_valid) begin
            chk("resp_one_source", exc_resp_valid & ex_resp_valid, 0);
            if (resp_q.size() == 0) begin
               chk("resp_unexpected", 1, 0);
            end else begin
               r = resp_q.pop_front();
               chk("resp_cycle", cyc, r.c);
               chk("resp_src", ex_resp_valid, r.src);
               chk("resp_rdata", resp_rdata, r.d);
               chk("resp_err", resp_err, r.e);
            end
         end
         if (csr_ren) begin
            chk("ren_wen_exclusive", csr_wen, 0);
            if (ren_q.size() == 0) begin
               chk("ren_unexpected", 1, 0);
            end else begin
               w = ren_q.pop_front();
               chk("ren_cycle", cyc, w.c);
               chk("ren_addr", csr_addr, w.a);
            end
         end
         if (csr_wen) begin
            if (wr_q.size() == 0) begin
               chk("wen_unexpected", 1, 0);
            end else begin
               w = wr_q.pop_front();
               chk("wen_cycle", cyc, w.c);
               chk("wen_addr", csr_addr, w.a);
               chk("wen_data", csr_wdata, w.d);
            end
         end
         if (!csr_ren && !csr_wen) begin
            chk("idle_csr_addr", csr_addr, 0);
            chk("idle_csr_wdata", csr_wdata, 0);
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      int src, f, op_i;
      bit pre, rmid;
      logic [1:0]  op;
      logic [13:0] a;
      logic [31:0] wd, mk;

      rstn = 1'b0; flush = 1'b0; mem_load = 1'b1;
      exc_valid = 1'b0; exc_op = '0; exc_addr = '0; exc_wdata = '0; exc_mask = '0;
      ex_valid = 1'b0; ex_op = '0; ex_addr = '0; ex_wdata = '0; ex_mask = '0;
      for (int i = 0; i < 16; i++) begin
         seed[i]   = $urandom;
         shadow[i] = seed[i];
      end
      repeat (2) @(posedge clk);
      #1 mem_load = 1'b0;
      @(negedge clk);
      chk_all_zero("reset");
      @(posedge clk); #1;
      rstn = 1'b1;

      // Directed cases.
      run_txn(0, 2'b01, 14'h0006, 32'h1234_5678, 32'h0, 0, 0, 0);
      run_txn(1, 2'b00, 14'h0006, 32'hDEAD_BEEF, 32'h0, 0, 0, 0);
      run_txn(0, 2'b01, 14'h0005, 32'hFFFF_0000, 32'h0, 0, 0, 0);
      run_txn(1, 2'b10, 14'h0005, 32'h0000_AAAA, 32'h0000_00FF, 0, 0, 0);
      run_txn(1, 2'b00, 14'h0005, 32'h0, 32'h0, 0, 0, 0);
      run_both(2'b00, 14'h0006, 32'h0, 32'h0, 0, 2'b01, 14'h0006, 32'hCAFE_F00D, 32'h0);
      run_txn(0, 2'b00, 14'h0006, 32'h0, 32'h0, 0, 0, 0);
      run_txn(1, 2'b01, 14'h0009, 32'h1111_2222, 32'h0, 2, 0, 0);
      run_txn(1, 2'b01, 14'h0009, 32'h3333_4444, 32'h0, 3, 0, 0);
      run_txn(1, 2'b00, 14'h0009, 32'h0, 32'h0, 1, 0, 0);
      run_txn(0, 2'b01, 14'h0009, 32'h5555_6666, 32'h0, 2, 0, 0);
      run_txn(1, 2'b11, 14'h0003, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
      run_txn(0, 2'b11, 14'h0004, 32'h0, 32'h0, 0, 0, 0);
      run_txn(1, 2'b01, 14'h000A, 32'h7777_8888, 32'h0, 0, 0, 1);
      run_txn(1, 2'b00, 14'h000A, 32'h0, 32'h0, 0, 1, 0);

      // Randomized traffic.
      for (int n = 0; n < 200; n++) begin
         op_i = $urandom_range(0, 3);
         op   = op_i[1:0];
         a    = 14'($urandom_range(0, 16383));
         wd   = $urandom;
         mk   = $urandom;
         if ($urandom_range(0, 5) == 0) begin
            run_both(op, a, wd, mk, ($urandom_range(0, 4) == 0) ? 2 : 0,
                     2'($urandom_range(0, 3)), 14'($urandom_range(0, 16383)), $urandom, $urandom);
         end else begin
            src  = $urandom_range(0, 1);
            f    = ($urandom_range(0, 9) < 3) ? $urandom_range(1, 4) : 0;
            pre  = ($urandom_range(0, 4) == 0);
            rmid = (op != 2'b11) && ($urandom_range(0, 39) == 0);
            run_txn(src, op, a, wd, mk, f, pre, rmid);
         end
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end

      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("resp_queue_drained", resp_q.size(), 0);
      chk("ren_queue_drained", ren_q.size(), 0);
      chk("wr_queue_drained", wr_q.size(), 0);
      for (int i = 0; i < 16; i++) chk("csr_file_contents", mem[i], shadow[i]);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/csr_port_arbiter.md
# csr_port_arbiter

Shares the single CSR-file access port between the exception/commit unit and the EX-stage privilege unit, and sequences every CSR instruction as a read-then-optional-write transaction. It sits between both requesters and the CSR register file. It implements CSRRD, CSRWR and CSRXCHG semantics: the old value is always returned, and the write data is merged under a mask for XCHG. It also supports flush cancellation of EX-side transactions.

## Interface
- `ADDR_W`, 14: CSR number width.
- `DATA_W`, 32: CSR data width.

- `clk`  in  1: clock.
- `rstn`  in  1: asynchronous active-low reset.
- `exc_valid` / `ex_valid`  in  1: request valid from exception unit / EX privilege unit.
- `exc_ready` / `ex_ready`  out  1: request accepted this cycle.
- `exc_op` / `ex_op`  in  2: `00` RD, `01` WR, `10` XCHG, `11` illegal.
- `exc_addr` / `ex_addr`  in  ADDR_W: CSR number.
- `exc_wdata` / `ex_wdata`  in  DATA_W: new value.
- `exc_mask` / `ex_mask`  in  DATA_W: XCHG mask; ignored otherwise.
- `exc_resp_valid` / `ex_resp_valid`  out  1: one-cycle response pulse.
- `resp_rdata`  out  DATA_W: old CSR value; valid with either response pulse.
- `resp_err`  out  1: illegal op; valid with either response pulse.
- `flush`  in  1: pipeline flush; affects EX-side transactions only.
- `busy`  out  1: state is not IDLE.
- `csr_addr`  out  ADDR_W: CSR file address.
- `csr_ren`  out  1: CSR file read enable.
- `csr_wen`  out  1: CSR file write enable.
- `csr_wdata`  out  DATA_W: CSR file write data.
- `csr_rdata`  in  DATA_W: CSR file read data; registered, valid the cycle after `csr_ren`.

## Operation
- **States:** IDLE, READ, CAPT, WRITE, RESP.
- **Arbitration (IDLE only)**
  - Fixed priority: exception over EX.
  - Winner gets `*_ready=1` combinationally.
  - On accept, register op, addr, wdata, mask, source and err; go to READ.
  - `ex_valid` with `flush` in the same cycle is not accepted.
  - EX starvation under continuous exception requests is accepted.
- **Illegal op (`11`):** accepted, goes IDLE→RESP directly. No CSR access, `resp_rdata=0`, `resp_err=1`.
- **READ:** `csr_ren=1`, `csr_addr=addr_q`; → CAPT.
- **CAPT:** `old_q<=csr_rdata`; RD → RESP, WR/XCHG → WRITE.
- **WRITE:** `csr_wen=1`; → RESP.
  - WR: `csr_wdata = wdata_q`.
  - XCHG: `csr_wdata = (wdata_q & mask_q) | (old_q & ~mask_q)`.
- **RESP:** pulse the source's `*_resp_valid` with `resp_rdata=old_q` and `resp_err=err_q`; → IDLE.
- **Flush (EX-sourced transactions only)**
  - `flush` in READ or CAPT: abort to IDLE next cycle; no write, no response.
  - `flush` in WRITE or RESP: write still completes; response suppressed.
  - Exception-sourced transactions ignore `flush`.
- **Idle outputs:** `csr_ren`, `csr_wen`, `csr_addr`, `csr_wdata` are all 0 in every state except where listed above.

## Timing
- **Reset:** state IDLE. Every output is 0: `ready`s, `resp_valid`s, `resp_rdata`, `resp_err`, `busy`, and all `csr_*`. Registered fields are cleared.
- **Latency, accept at cycle T:**
  - RD: `csr_ren` at T+1, response at T+3.
  - WR/XCHG: `csr_wen` at T+3, response at T+4.
  - Illegal: response at T+1.
- **Throughput:** one transaction in flight. The next accept occurs at the earliest in the cycle after RESP.
- **Back-to-back ordering:** a read issued after a write to the same CSR observes the new value, because the write commits before RESP.
- **Reset mid-transaction:** immediate return to IDLE. A write not yet issued is lost; no response is given.
- **Response outputs:** `resp_rdata` and `resp_err` hold their last value outside response pulses.

## Structure
- Op encodings `CSR_OP_RD`, `CSR_OP_WR`, `CSR_OP_XCHG` and `CSR_OP_ILL` belong in the shared `define.vh`.
- State localparams stay local to the module.
- No sub-module is needed. The XCHG merge is a local function.

## Test plan
- **RD:** `ex` RD addr 0x0006, CSR holds 0x1234_5678 → `csr_ren` at T+1; `ex_resp_valid` at T+3 with 0x1234_5678; no `csr_wen`.
- **XCHG:** CSR 0xFFFF_0000, `wdata` 0x0000_AAAA, mask 0x0000_00FF → write 0xFFFF_00AA at T+3; response 0xFFFF_0000 at T+4.
- **Simultaneous valids:** both valid in IDLE → exception served first (`exc_ready=1`, `ex_ready=0`). EX is accepted at the cycle after exception RESP, and its response follows.
- **Flush timing:** EX WR with `flush` at T+2 → no `csr_wen`, no response, IDLE at T+3. EX WR with `flush` at T+3 → `csr_wen` at T+3, `ex_resp_valid` suppressed.
- **Illegal op:** `ex_op=11` → `ex_resp_valid` at T+1 with `resp_err=1` and `resp_rdata=0`; no `csr_ren` or `csr_wen`.
- **Reset mid-write:** `rstn` low during CAPT of a WR → all outputs 0; no write issued after release; next request is handled normally.
